// File: rtl/boton_pkg.sv
// boton_pkg: shared FSM encodings, 50 MHz board timing defaults and sizing helper for the button conditioner
package boton_pkg;

   typedef logic [1:0] estado_t;

   localparam estado_t SUELTO        = 2'd0;
   localparam estado_t ESPERA_PULSA  = 2'd1;
   localparam estado_t PULSADO       = 2'd2;
   localparam estado_t ESPERA_SUELTA = 2'd3;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int REPEAT_DELAY_DEF    = 25000000;
   localparam int REPEAT_PERIOD_DEF   = 5000000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador: N-flop synchronizer for an asynchronous single-bit input, async active-low reset to RESET_VAL
module sincronizador #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] ff_q;

   // shift the raw input through the flop chain; bit 0 is the metastability catcher
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff_q <= {STAGES{RESET_VAL}};
      else        ff_q <= {ff_q[STAGES-2:0], d_i};
   end

   assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/boton_antirrebote.sv
// boton_antirrebote: debounces a raw push-button into a one-cycle press strobe, with optional hold-to-repeat
module boton_antirrebote
   import boton_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int ACTIVE_HIGH     = 1,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       boton,
   output logic       pulso,
   output logic       nivel,
   output logic [7:0] rechazos
);

   localparam int            CW      = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic          INACT   = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

   estado_t       estado_q, estado_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          primero_q, primero_d;
   logic [7:0]    rech_q, rech_d, rech_inc;
   logic          pulso_q, pulso_d;
   logic          nivel_q, nivel_d;
   logic          sync_s, b;

   sincronizador #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (INACT)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (boton),
      .q_o   (sync_s)
   );

   assign b        = sync_s ^ INACT;
   assign rech_inc = (rech_q == 8'hFF) ? rech_q : rech_q + 8'd1;

   // next-state, dwell counter, repeat phase and glitch count; outputs decoded from the next state
   always_comb begin
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      primero_d = primero_q;
      rech_d    = rech_q;
      pulso_d   = 1'b0;
      case (estado_q)
         SUELTO: begin
            cnt_d = '0;
            if (b) begin
               estado_d = ESPERA_PULSA;
               cnt_d    = CW'(1);
            end
         end
         ESPERA_PULSA: begin
            if (!b) begin
               estado_d = SUELTO;
               cnt_d    = '0;
               rech_d   = rech_inc;
            end else if (cnt_q == DB_LAST) begin
               estado_d  = PULSADO;
               pulso_d   = 1'b1;
               cnt_d     = '0;
               primero_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PULSADO: begin
            if (!b) begin
               estado_d = ESPERA_SUELTA;
               cnt_d    = CW'(1);
            end else if (REPEAT_EN == 0) begin
               cnt_d = '0;
            end else if (cnt_q == (primero_q ? RD_LAST : RP_LAST)) begin
               pulso_d   = 1'b1;
               cnt_d     = '0;
               primero_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ESPERA_SUELTA: begin
            if (b) begin
               estado_d  = PULSADO;
               cnt_d     = '0;
               primero_d = 1'b1;
               rech_d    = rech_inc;
            end else if (cnt_q == DB_LAST) begin
               estado_d = SUELTO;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            estado_d = SUELTO;
            cnt_d    = '0;
         end
      endcase
      nivel_d = (estado_d == PULSADO) || (estado_d == ESPERA_SUELTA);
   end

   // state and registered outputs; reset clears everything so a held button must re-qualify
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= SUELTO;
         cnt_q     <= '0;
         primero_q <= 1'b1;
         rech_q    <= '0;
         pulso_q   <= 1'b0;
         nivel_q   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         primero_q <= primero_d;
         rech_q    <= rech_d;
         pulso_q   <= pulso_d;
         nivel_q   <= nivel_d;
      end
   end

   assign pulso    = pulso_q;
   assign nivel    = nivel_q;
   assign rechazos = rech_q;

endmodule

// File: tb/tb_boton_antirrebote.sv
// tb_boton_antirrebote: directed checks of debounce timing, glitch rejection, repeat and async reset
module tb_boton_antirrebote;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       boton;
   logic       p0, n0, p1, n1;
   logic [7:0] r0, r1;
   int         total = 0, passed = 0, fails = 0;
   int         pc0 = 0, pc1 = 0, dbl = 0;
   logic       prev0 = 1'b0, prev1 = 1'b0;

   always #5 clk = ~clk;

   boton_antirrebote #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_HIGH(1),
      .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .boton(boton), .pulso(p0), .nivel(n0), .rechazos(r0)
   );

   boton_antirrebote #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_HIGH(1),
      .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .boton(boton), .pulso(p1), .nivel(n1), .rechazos(r1)
   );

   // pulse counters and back-to-back pulse detector, sampled mid-cycle
   always @(negedge clk) begin
      if (p0) pc0 = pc0 + 1;
      if (p1) pc1 = pc1 + 1;
      if ((p0 && prev0) || (p1 && prev1)) dbl = dbl + 1;
      prev0 = p0;
      prev1 = p1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      boton = 1'b1;
      #23;
      chk("rst_pulso", {31'd0, p0}, 0);
      chk("rst_nivel", {31'd0, n0}, 0);
      chk("rst_rech", {24'd0, r0}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(5);
      chk("rst_early_pulso", {31'd0, p0}, 0);
      chk("rst_early_nivel", {31'd0, n0}, 0);
      tick(1);
      chk("rst_first_pulso", {31'd0, p0}, 1);
      chk("rst_first_nivel", {31'd0, n0}, 1);
      tick(1);
      chk("pulso_width", {31'd0, p0}, 0);
      boton = 1'b0;
      tick(8);
      chk("rst_released", {31'd0, n0}, 0);
      // clean press
      pc0 = 0;
      boton = 1'b1;
      tick(5);
      chk("clean_pre", {31'd0, p0}, 0);
      tick(1);
      chk("clean_pulso", {31'd0, p0}, 1);
      chk("clean_nivel", {31'd0, n0}, 1);
      tick(19);
      chk("clean_count", pc0, 1);
      boton = 1'b0;
      tick(5);
      chk("rel_nivel_hold", {31'd0, n0}, 1);
      tick(1);
      chk("rel_nivel_drop", {31'd0, n0}, 0);
      tick(3);
      chk("rel_no_pulse", pc0, 1);
      // press bounce: high 2, low 1, high 2, low 1, then steady high
      pc0 = 0;
      begin
         logic [5:0] pat;
         pat = 6'b011011;
         for (int i = 0; i < 6; i++) begin
            boton = pat[i];
            tick(1);
         end
      end
      boton = 1'b1;
      tick(5);
      chk("bounce_rech", {24'd0, r0}, 2);
      chk("bounce_pre", {31'd0, p0}, 0);
      chk("bounce_none_yet", pc0, 0);
      tick(1);
      chk("bounce_pulso", {31'd0, p0}, 1);
      tick(2);
      // release chatter while held
      pc0 = 0;
      begin
         logic [3:0] pat;
         pat = 4'b1010;
         for (int i = 0; i < 4; i++) begin
            boton = pat[i];
            tick(1);
         end
      end
      boton = 1'b1;
      tick(1);
      chk("chatter_nivel_mid", {31'd0, n0}, 1);
      tick(3);
      chk("chatter_rech", {24'd0, r0}, 4);
      chk("chatter_nivel", {31'd0, n0}, 1);
      chk("chatter_no_pulse", pc0, 0);
      boton = 1'b0;
      tick(8);
      chk("chatter_release", {31'd0, n0}, 0);
      // hold-to-repeat
      pc0 = 0;
      pc1 = 0;
      boton = 1'b1;
      tick(6);
      chk("rep_accept", {31'd0, p1}, 1);
      for (int j = 1; j <= 30; j++) begin
         tick(1);
         chk($sformatf("rep_pulso_%0d", j), {31'd0, p1}, (j >= 10 && j % 5 == 0) ? 1 : 0);
      end
      tick(1);
      chk("rep_count", pc1, 6);
      chk("norep_count", pc0, 1);
      chk("no_double_pulse", dbl, 0);
      boton = 1'b0;
      tick(8);
      // glitch saturation
      for (int g = 0; g < 250; g++) begin
         boton = 1'b1;
         tick(1);
         boton = 1'b0;
         tick(1);
      end
      tick(4);
      chk("rech_254", {24'd0, r0}, 254);
      for (int g = 0; g < 50; g++) begin
         boton = 1'b1;
         tick(1);
         boton = 1'b0;
         tick(1);
      end
      tick(4);
      chk("rech_sat", {24'd0, r0}, 255);
      chk("rech_sat_rep", {24'd0, r1}, 255);
      chk("glitch_no_pulse", {31'd0, n0}, 0);
      // async reset mid-PULSADO
      boton = 1'b1;
      tick(8);
      chk("pre_arst_nivel", {31'd0, n0}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_nivel", {31'd0, n0}, 0);
      chk("arst_rech", {24'd0, r0}, 0);
      chk("arst_pulso", {31'd0, p1}, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(5);
      chk("arst_wait", {31'd0, p0}, 0);
      tick(1);
      chk("arst_fresh_pulso", {31'd0, p0}, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
